// File: rtl/range_hit_accumulator.sv
// Purpose: per-window statistics (class hits, misses, max) over comparator-flagged 4-bit samples.
// Latency: rpt_valid rises the cycle after the edge that accepts the WINDOW-th sample.
// Backpressure: data_ready is low while a report waits; rpt_ready low stalls the input stream.
module range_hit_accumulator #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [3:0]       data,
  input  logic             in_range1,
  input  logic             in_range2,
  input  logic             in_range3,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_cnt1,
  output logic [CNT_W-1:0] rpt_cnt2,
  output logic [CNT_W-1:0] rpt_cnt3,
  output logic [CNT_W-1:0] rpt_miss,
  output logic [3:0]       rpt_max
);

  localparam logic [0:0] ST_ACCUM  = 1'b0;
  localparam logic [0:0] ST_REPORT = 1'b1;

  // Index of the final sample of a window; smp_cnt never needs to reach WINDOW itself.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] smp_cnt;
  logic [CNT_W-1:0] acc1;
  logic [CNT_W-1:0] acc2;
  logic [CNT_W-1:0] acc3;
  logic [CNT_W-1:0] accm;
  logic [3:0]       accmax;

  logic             accept;
  logic             window_done;
  logic             handshake;
  logic             no_hit;

  logic [CNT_W-1:0] acc1_nxt;
  logic [CNT_W-1:0] acc2_nxt;
  logic [CNT_W-1:0] acc3_nxt;
  logic [CNT_W-1:0] accm_nxt;
  logic [3:0]       accmax_nxt;

  // Ready depends only on state and the two control inputs, never on rpt_ready.
  assign data_ready  = (state == ST_ACCUM) && rst_n && !clear;
  assign accept      = data_valid && data_ready;
  assign window_done = accept && (smp_cnt == LAST_IDX);
  assign handshake   = (state == ST_REPORT) && rpt_valid && rpt_ready;

  // Flags are trusted as presented; a value can land in two classes (5 is in range 1 and 2).
  assign no_hit = !in_range1 && !in_range2 && !in_range3;

  // Totals including the current sample, used both for accumulation and for the final report load.
  always_comb begin
    acc1_nxt   = acc1 + CNT_W'(in_range1);
    acc2_nxt   = acc2 + CNT_W'(in_range2);
    acc3_nxt   = acc3 + CNT_W'(in_range3);
    accm_nxt   = accm + CNT_W'(no_hit);
    accmax_nxt = (data > accmax) ? data : accmax;
  end

  // Control FSM: ACCUM until the window closes, REPORT until the report is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_ACCUM;
      rpt_valid <= 1'b0;
    end else if (clear) begin
      state     <= ST_ACCUM;
      rpt_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (window_done) begin
            state     <= ST_REPORT;
            rpt_valid <= 1'b1;
          end
        end
        ST_REPORT: begin
          if (handshake) begin
            state     <= ST_ACCUM;
            rpt_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_ACCUM;
          rpt_valid <= 1'b0;
        end
      endcase
    end
  end

  // Running accumulators: advance on accept, restart from zero when the window closes.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      smp_cnt <= '0;
      acc1    <= '0;
      acc2    <= '0;
      acc3    <= '0;
      accm    <= '0;
      accmax  <= '0;
    end else if (window_done) begin
      smp_cnt <= '0;
      acc1    <= '0;
      acc2    <= '0;
      acc3    <= '0;
      accm    <= '0;
      accmax  <= '0;
    end else if (accept) begin
      smp_cnt <= smp_cnt + 1'b1;
      acc1    <= acc1_nxt;
      acc2    <= acc2_nxt;
      acc3    <= acc3_nxt;
      accm    <= accm_nxt;
      accmax  <= accmax_nxt;
    end
  end

  // Report registers: load once per window and hold until the next window closes.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rpt_cnt1 <= '0;
      rpt_cnt2 <= '0;
      rpt_cnt3 <= '0;
      rpt_miss <= '0;
      rpt_max  <= '0;
    end else if (window_done) begin
      rpt_cnt1 <= acc1_nxt;
      rpt_cnt2 <= acc2_nxt;
      rpt_cnt3 <= acc3_nxt;
      rpt_miss <= accm_nxt;
      rpt_max  <= accmax_nxt;
    end
  end

endmodule

// File: tb/tb_range_hit_accumulator.sv
// Purpose: scoreboard bench for range_hit_accumulator (WINDOW=16).
// Latency: inputs change 1ns after each rising edge, outputs are checked 1ns later.
// Backpressure: rpt_ready is driven per cycle to exercise stalls and handshakes.
module tb_range_hit_accumulator;

  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);

  typedef struct {
    int c1;
    int c2;
    int c3;
    int miss;
    int mx;
  } rpt_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          data_valid;
  logic          data_ready;
  logic [3:0]    data;
  logic          in_range1;
  logic          in_range2;
  logic          in_range3;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [CW-1:0] rpt_cnt1;
  logic [CW-1:0] rpt_cnt2;
  logic [CW-1:0] rpt_cnt3;
  logic [CW-1:0] rpt_miss;
  logic [3:0]    rpt_max;

  int   n_vec  = 0;
  int   n_miss = 0;

  rpt_t sb[$];
  rpt_t m_acc;
  rpt_t m_last;
  rpt_t zero_rpt = '{0, 0, 0, 0, 0};
  int   m_n      = 0;
  bit   m_pend   = 1'b0;
  bit   m_known  = 1'b0;

  always #5 clk = ~clk;

  range_hit_accumulator #(.WINDOW(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data       (data),
    .in_range1  (in_range1),
    .in_range2  (in_range2),
    .in_range3  (in_range3),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_cnt1   (rpt_cnt1),
    .rpt_cnt2   (rpt_cnt2),
    .rpt_cnt3   (rpt_cnt3),
    .rpt_miss   (rpt_miss),
    .rpt_max    (rpt_max)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance the reference model.
  task automatic cyc(input bit rst, input bit vld, input int d, input bit rdy, input bit clr);
    rpt_t exp_r;
    rst_n      = rst;
    clear      = clr;
    data_valid = vld;
    data       = 4'(d);
    in_range1  = (d >= 3 && d <= 7);
    in_range2  = (d == 2 || d == 5 || d == 9);
    in_range3  = (d >= 10 && d <= 15);
    rpt_ready  = rdy;
    #1;
    if (m_known) begin
      exp_r = (m_pend && sb.size() > 0) ? sb[0] : m_last;
      chk("data_ready", int'(data_ready), int'(!m_pend && rst && !clr));
      chk("rpt_valid", int'(rpt_valid), int'(m_pend));
      chk("rpt_cnt1", int'(rpt_cnt1), exp_r.c1);
      chk("rpt_cnt2", int'(rpt_cnt2), exp_r.c2);
      chk("rpt_cnt3", int'(rpt_cnt3), exp_r.c3);
      chk("rpt_miss", int'(rpt_miss), exp_r.miss);
      chk("rpt_max", int'(rpt_max), exp_r.mx);
    end
    if (!rst || clr) begin
      if (!rst) m_known = 1'b1;
      sb.delete();
      m_acc  = zero_rpt;
      m_last = zero_rpt;
      m_n    = 0;
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (rdy) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else m_last = sb.pop_front();
        m_pend = 1'b0;
      end
    end else if (vld) begin
      m_acc.c1   += int'(in_range1);
      m_acc.c2   += int'(in_range2);
      m_acc.c3   += int'(in_range3);
      m_acc.miss += int'(!in_range1 && !in_range2 && !in_range3);
      if (d > m_acc.mx) m_acc.mx = d;
      m_n++;
      if (m_n == W) begin
        sb.push_back(m_acc);
        m_acc  = zero_rpt;
        m_n    = 0;
        m_pend = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, rdy, 1'b0);
  endtask

  initial begin
    m_acc  = zero_rpt;
    m_last = zero_rpt;

    // Reset
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3, 1'b1, 1'b0);
    idle(1, 1'b0);

    // Full sweep 0..15, report taken immediately
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, i, 1'b1, 1'b0);
    chk("sweep_pending", int'(m_pend), 1);
    idle(3, 1'b1);
    chk("sweep_c1", m_last.c1, 5);
    chk("sweep_c2", m_last.c2, 3);
    chk("sweep_c3", m_last.c3, 6);
    chk("sweep_miss", m_last.miss, 3);
    chk("sweep_max", m_last.mx, 15);

    // Overlap: value 5 hits range 1 and range 2
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 5, 1'b1, 1'b0);
    idle(2, 1'b1);
    chk("overlap_c1", m_last.c1, 16);
    chk("overlap_c2", m_last.c2, 16);

    // Backpressure: window done, 5 stalled cycles with data offered, then handshake
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, (i * 7) % 16, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 15, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 15, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 16 - i - 1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Bubbles: data 8 on odd cycles only
    for (int i = 0; i < 32; i++) cyc(1'b1, bit'(i % 2), 8, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("bubble_miss", m_last.miss, 16);
    chk("bubble_max", m_last.mx, 8);

    // Clear after 7 samples of 12, sample offered during clear, then 16 samples of 1
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 12, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 12, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1, 1'b1, 1'b0);
    idle(2, 1'b1);
    chk("clear_c3", m_last.c3, 0);
    chk("clear_miss", m_last.miss, 16);
    chk("clear_max", m_last.mx, 1);

    // Reset while a report is pending, then a fresh sweep
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 11, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 1'b1, 4, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, i, 1'b1, 1'b0);
    idle(2, 1'b1);
    chk("rst_sweep_c1", m_last.c1, 5);
    chk("rst_sweep_miss", m_last.miss, 3);
    chk("rst_sweep_max", m_last.mx, 15);

    // Random traffic with occasional clear
    for (int i = 0; i < 400; i++) begin
      cyc(1'b1, bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
          bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 60) == 0));
    end
    idle(4, 1'b1);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
